adc_uart_tx: RTL and testbench
==============================

ADC_UART_TX -- requirements
Module: adc_uart_tx

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-002 SHALL have port clk_i  input  1  system clock; the block uses this one clock only.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port eos_i  input  1  one-cycle pulse: both channel samples valid (end of ADC sequence).
REQ-005 SHALL have port ch0_i  input  12  channel-0 sample.
REQ-006 SHALL have port ch1_i  input  12  channel-1 sample.
REQ-007 SHALL have port baud_i  input  16  clocks per UART bit minus 1.
REQ-008 SHALL have port tx_o  output  1  UART serial line, idle high.
REQ-009 SHALL have port busy_o  output  1  high while a frame is being sent.
REQ-010 SHALL have port eot_o  output  1  one-cycle pulse: frame complete.
REQ-011 SHALL have port ovf_o  output  1  sticky flag: eos_i dropped while busy.

Function
REQ-012 SHALL accept eos_i only when busy_o=0; on acceptance it latches ch0_i, ch1_i and baud_i in that clock edge.
REQ-013 SHALL form a 5-byte frame: HEADER, ch0[11:4], {ch0[3:0],ch1[11:8]}, ch1[7:0], CHK.
REQ-014 SHALL compute CHK as the XOR of bytes 1-3; HEADER is excluded from CHK.
REQ-015 SHALL send each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-016 SHALL hold every bit for exactly baud_i+1 clocks, using the latched baud value; baud_i=0 gives a 1-clock bit.
REQ-017 SHALL drive the start bit of byte 0 on tx_o starting the cycle after the accepting edge (latency 1).
REQ-018 SHALL send the bytes back-to-back, with no idle gap between a stop bit and the next start bit.
REQ-019 SHALL take 50*(baud_i+1) clocks per frame, from the first start-bit cycle to the end of the last stop bit.
REQ-020 SHALL use a state machine with states IDLE, START, DATA, STOP:
  - IDLE -> START on accepted eos_i;
  - START -> DATA after one bit time;
  - DATA -> STOP after 8 bit times;
  - STOP -> START if byte index < 4, with the index incremented;
  - STOP -> IDLE if byte index = 4.
REQ-021 SHALL assert busy_o in START, DATA and STOP, and deassert it in IDLE.
REQ-022 SHALL pulse eot_o for one cycle in the first IDLE cycle after the last stop bit, with busy_o=0 in that cycle.
REQ-023 SHALL accept an eos_i that coincides with the eot_o cycle; start-bit latency is unchanged.
REQ-024 SHALL, on eos_i while busy_o=1:
  - ignore the sample;
  - leave the frame in flight unaffected;
  - set ovf_o, which stays set until reset.
REQ-025 SHALL ignore changes on ch0_i, ch1_i and baud_i while busy.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge, force:
  - state IDLE, byte index 0, bit and baud counters 0;
  - tx_o=1, busy_o=0, eot_o=0, ovf_o=0.
REQ-027 SHALL abort a frame in progress when reset arrives mid-frame: tx_o returns high the next cycle, no eot_o pulse.
REQ-028 SHALL give rst_i priority over a simultaneous eos_i.

Structure
REQ-029 SHALL keep the state encoding, the frame length (5), the bits per byte (8) and the default HEADER in a shared package used by TX-side blocks.
REQ-030 SHALL contain one sub-module, uart_tx_byte: it takes a byte plus a start strobe, and returns tx and a done pulse, driven by the latched baud count.
REQ-031 SHALL place the frame assembly, CHK, ovf logic and byte sequencing in adc_uart_tx; the output registers tx_o, busy_o and eot_o have no combinational path from inputs.

Verification
REQ-032 SHALL cover the basic frame: ch0=12'hABC, ch1=12'h123, baud_i=3, eos pulse -> tx_o bytes A5, AB, C1, 23, 49, 4 clocks/bit; eot_o exactly 200 clocks after the first start bit begins.
REQ-033 SHALL cover overflow: a second eos_i 50 clocks into the frame -> frame bytes unchanged, ovf_o=1 and staying 1, only one eot_o.
REQ-034 SHALL cover the coincident case: eos_i in the eot_o cycle with ch0=12'h000, ch1=12'hFFF, baud_i=0 -> start bit the next cycle, bytes A5, 00, 0F, FF, F0, frame 50 clocks, ovf_o=0.
REQ-035 SHALL cover reset mid-frame: rst_i at byte 2, bit 3 -> next cycle tx_o=1, busy_o=0; no eot_o; a following eos sends a full correct frame.
REQ-036 SHALL cover latching: baud_i changes from 3 to 7 and ch0_i changes mid-frame -> the current frame keeps 4 clocks/bit and the original data; the next frame uses 8 clocks/bit.
REQ-037 SHALL cover idle: no eos for 1000 clocks after reset -> tx_o=1, busy_o=0, eot_o never pulses.

Source files
------------

// File: rtl/adc_uart_tx_pkg.sv
// Shared definitions for the ADC sample UART transmitter blocks.
package adc_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int          FRAME_LEN      = 5;
    localparam int          BITS_PER_BYTE  = 8;
    localparam int          IDX_W          = 3;
    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

    // Byte idx of the frame: header, packed 24-bit sample pair, XOR check of bytes 1-3.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [7:0]       hdr,
                                              input logic [11:0]      ch0,
                                              input logic [11:0]      ch1);
        logic [7:0] b1, b2, b3;
        b1 = ch0[11:4];
        b2 = {ch0[3:0], ch1[11:8]};
        b3 = ch1[7:0];
        case (idx)
            3'd0:    frame_byte = hdr;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = b2;
            3'd3:    frame_byte = b3;
            default: frame_byte = b1 ^ b2 ^ b3;
        endcase
    endfunction

endpackage

// File: rtl/adc_uart_tx_byte.sv
// One 8N1 byte shifter. A start strobe in STOP's last cycle chains the next
// byte with no idle gap; o_done marks the final cycle of the stop bit.
module uart_tx_byte
    import adc_uart_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic [15:0] i_baud,
    output logic        o_tx,
    output logic        o_done
);

    tx_state_t   r_state,    w_state_nx;
    logic [15:0] r_baud_cnt, w_baud_cnt_nx;
    logic [2:0]  r_bit_cnt,  w_bit_cnt_nx;
    logic [7:0]  r_shift,    w_shift_nx;
    logic        r_tx,       w_tx_nx;
    logic        w_bit_end;

    assign w_bit_end = (r_baud_cnt == i_baud);
    assign o_done    = (r_state == STOP) && w_bit_end;
    assign o_tx      = r_tx;

    // Next-state: one bit every i_baud+1 clocks; tx is registered so it lines up with the state.
    always_comb begin
        w_state_nx    = r_state;
        w_baud_cnt_nx = r_baud_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_tx_nx       = r_tx;
        if (r_state != IDLE)
            w_baud_cnt_nx = w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nx    = START;
                    w_tx_nx       = 1'b0;
                    w_shift_nx    = i_byte;
                    w_baud_cnt_nx = 16'd0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nx   = DATA;
                    w_tx_nx      = r_shift[0];
                    w_bit_cnt_nx = 3'd0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                        w_state_nx = STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        w_shift_nx   = r_shift >> 1;
                        w_tx_nx      = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (i_start) begin
                        w_state_nx = START;
                        w_tx_nx    = 1'b0;
                        w_shift_nx = i_byte;
                    end else begin
                        w_state_nx = IDLE;
                        w_tx_nx    = 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State register; reset parks the line high in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_tx       <= w_tx_nx;
        end
    end

endmodule

// File: rtl/adc_uart_tx.sv
// Frames a two-channel ADC sample pair (header, 3 data bytes, XOR check) and
// sends it over UART. Samples arriving while a frame is in flight are dropped
// and flagged on the sticky ovf_o.
module adc_uart_tx
    import adc_uart_tx_pkg::*;
#(
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eos_i,
    input  logic [11:0] ch0_i,
    input  logic [11:0] ch1_i,
    input  logic [15:0] baud_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        eot_o,
    output logic        ovf_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [11:0]      r_ch0, r_ch1;
    logic [15:0]      r_baud;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy, r_eot, r_ovf;
    logic             w_accept, w_done, w_last, w_start;
    logic [7:0]       w_byte;

    assign w_accept = eos_i & ~r_busy;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_start  = w_accept | (w_done & ~w_last);
    // Header goes out straight from the accept edge; later bytes come from latched samples.
    assign w_byte   = w_accept ? HEADER
                               : frame_byte(r_idx + 3'd1, HEADER, r_ch0, r_ch1);

    uart_tx_byte u_byte (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_start (w_start),
        .i_byte  (w_byte),
        .i_baud  (r_baud),
        .o_tx    (tx_o),
        .o_done  (w_done)
    );

    // Sample latch, byte sequencing, end-of-frame pulse and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ch0  <= 12'd0;
            r_ch1  <= 12'd0;
            r_baud <= 16'd0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_eot  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_eot <= w_done & w_last;
            r_ovf <= r_ovf | (eos_i & r_busy);
            if (w_accept) begin
                r_ch0  <= ch0_i;
                r_ch1  <= ch1_i;
                r_baud <= baud_i;
                r_idx  <= '0;
                r_busy <= 1'b1;
            end else if (w_done) begin
                if (w_last) begin
                    r_idx  <= '0;
                    r_busy <= 1'b0;
                end else begin
                    r_idx  <= r_idx + 3'd1;
                end
            end
        end
    end

    assign busy_o = r_busy;
    assign eot_o  = r_eot;
    assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_adc_uart_tx.sv
// Scoreboard bench: stimulus pushes expected frames (bit image + bit time),
// an independent monitor decodes the serial line cycle by cycle.
module tb_adc_uart_tx;

    typedef struct {
        logic [49:0] bits;
        int          baud;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eos = 1'b0;
    logic [11:0] ch0 = 12'd0;
    logic [11:0] ch1 = 12'd0;
    logic [15:0] baud = 16'd0;
    logic        tx_o, busy_o, eot_o, ovf_o;

    int     vectors     = 0;
    int     miscompares = 0;
    int     ecount      = 0;
    int     busy_until  = 0;
    int     last_a      = 0;
    logic   exp_ovf     = 1'b0;
    bit     mon_en      = 1'b0;
    frame_t exp_q[$];

    adc_uart_tx dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .eos_i  (eos),
        .ch0_i  (ch0),
        .ch1_i  (ch1),
        .baud_i (baud),
        .tx_o   (tx_o),
        .busy_o (busy_o),
        .eot_o  (eot_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference frame: header A5, packed samples, XOR check; each byte 8N1 LSB first.
    function automatic logic [49:0] model_bits(input logic [11:0] a, input logic [11:0] b);
        logic [7:0]  by [5];
        logic [49:0] r;
        by[0] = 8'hA5;
        by[1] = a[11:4];
        by[2] = {a[3:0], b[11:8]};
        by[3] = b[7:0];
        by[4] = by[1] ^ by[2] ^ by[3];
        for (int k = 0; k < 5; k++) begin
            r[k*10] = 1'b0;
            for (int j = 0; j < 8; j++) r[k*10+1+j] = by[k][j];
            r[k*10+9] = 1'b1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (ecount < n) tick();
    endtask

    // Pulse eos for one edge; the model decides accept vs overflow from the busy window.
    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [15:0] bd);
        int     e;
        frame_t f;
        ch0 = a; ch1 = b; baud = bd; eos = 1'b1;
        e = ecount + 1;
        if (e <= busy_until) begin
            exp_ovf = 1'b1;
        end else begin
            f.bits = model_bits(a, b);
            f.baud = int'(bd);
            exp_q.push_back(f);
            last_a     = e;
            busy_until = e + 50 * (int'(bd) + 1);
        end
        tick();
        eos = 1'b0;
    endtask

    task automatic check_ovf(input string nm);
        chk(nm, ovf_o, exp_ovf);
    endtask

    // Monitor: idle line checks, then cycle-exact decode of each frame.
    initial begin : monitor
        logic       prev_busy;
        logic       abort;
        logic [2:0] obs;
        frame_t     f;
        int         fn;
        prev_busy = 1'b0;
        fn = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (busy_o && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", exp_q.size(), 1);
                    prev_busy = busy_o;
                end else begin
                    f = exp_q.pop_front();
                    abort = 1'b0;
                    for (int b = 0; b < 50 && !abort; b++) begin
                        obs = {f.bits[b], 2'b10};
                        for (int c = 0; c <= f.baud && !abort; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if ({tx_o, busy_o, eot_o} !== {f.bits[b], 2'b10})
                                obs = {tx_o, busy_o, eot_o};
                            if (rst) abort = 1'b1;
                        end
                        if (!abort)
                            chk($sformatf("frame%0d_bit%0d", fn, b), obs, {f.bits[b], 2'b10});
                    end
                    @(negedge clk);
                    if (abort) chk($sformatf("frame%0d_reset_abort", fn), {tx_o, busy_o, eot_o}, 3'b100);
                    else       chk($sformatf("frame%0d_eot", fn), {tx_o, busy_o, eot_o}, 3'b101);
                    fn++;
                    prev_busy = busy_o;
                end
            end else begin
                if (!busy_o) chk("idle_line", {tx_o, eot_o}, 2'b10);
                prev_busy = busy_o;
            end
        end
    end

    initial begin : stim
        int          b, gap;
        logic [15:0] bd;
        repeat (3) tick();
        chk("reset_state", {tx_o, busy_o, eot_o, ovf_o}, 4'b1000);
        rst = 1'b0;
        mon_en = 1'b1;

        // idle after reset
        wait_edge(ecount + 1000);
        chk("idle_1000", {tx_o, busy_o, eot_o}, 3'b100);
        check_ovf("idle_ovf");

        // basic frame, then an eos in its eot cycle
        send(12'hABC, 12'h123, 16'd3);
        wait_edge(busy_until);
        send(12'h000, 12'hFFF, 16'd0);
        check_ovf("coincident_ovf");

        // overflow 50 clocks into a frame
        wait_edge(busy_until + 5);
        send(12'h111, 12'h222, 16'd3);
        wait_edge(last_a + 50);
        send(12'h999, 12'h888, 16'd1);
        check_ovf("ovf_set");
        wait_edge(busy_until + 2);
        check_ovf("ovf_sticky");

        // inputs change mid-frame; next frame uses the new bit time
        send(12'h5A5, 12'h3C3, 16'd3);
        wait_edge(last_a + 30);
        ch0 = 12'hFFF; ch1 = 12'h000; baud = 16'd7;
        wait_edge(busy_until + 2);
        send(12'h0F0, 12'h789, 16'd7);
        wait_edge(busy_until + 4);
        check_ovf("ovf_still_set");

        // reset at byte 2 data bit 3, then reset colliding with eos
        send(12'hDEF, 12'h456, 16'd2);
        wait_edge(last_a + 24 * 3 + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_until = 0;
        exp_ovf = 1'b0;
        chk("after_reset", {tx_o, busy_o, eot_o, ovf_o}, 4'b1000);
        tick(); tick();
        rst = 1'b1; eos = 1'b1;
        tick();
        rst = 1'b0; eos = 1'b0;
        chk("rst_over_eos", {tx_o, busy_o}, 2'b10);
        tick();
        send(12'hDEF, 12'h456, 16'd2);
        check_ovf("ovf_after_reset");

        // randomized frames, gaps (including coincident), input jitter and overflows
        for (int n = 0; n < 12; n++) begin
            gap = $urandom_range(0, 4);
            wait_edge(busy_until + gap);
            bd = 16'($urandom_range(0, 3));
            send(12'($urandom), 12'($urandom), bd);
            b = int'(bd);
            wait_edge(last_a + $urandom_range(1, 50 * (b + 1) - 2));
            ch0 = 12'($urandom); ch1 = 12'($urandom); baud = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) send(12'($urandom), 12'($urandom), 16'd0);
            check_ovf($sformatf("rand%0d_ovf", n));
        end

        wait_edge(busy_until + 4);
        chk("queue_drained", exp_q.size(), 0);
        check_ovf("final_ovf");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
